pc_sel_ctrl: RTL

// Next-PC sequencer for the RISC-V core fetch stage. Drives the 3-bit select of the 5-input PC mux.
// Mux inputs: PC+4 adder, branch/JAL target, JALR target, current PC (hold), RESET_PC.

---
 rtl/pc_sel_ctrl_pkg.sv | 35 +++
 rtl/pc_sel_ctrl_sat_counter.sv | 26 ++
 rtl/pc_sel_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pc_sel_ctrl_pkg.sv
// Shared encodings for the next-PC sequencer and the datapath MUX5 hookup.
// PC mux select codes, sequencer FSM states and the redirect decode helper.
package pc_sel_ctrl_pkg;

  localparam logic [2:0] SEL_PC4  = 3'd0;
  localparam logic [2:0] SEL_TGT  = 3'd1;
  localparam logic [2:0] SEL_JALR = 3'd2;
  localparam logic [2:0] SEL_HOLD = 3'd3;
  localparam logic [2:0] SEL_RST  = 3'd4;

  localparam int SQ_W = 3;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2
  } fsm_e;

  typedef struct packed {
    logic       any;
    logic       multi;
    logic [2:0] sel;
  } redir_t;

  // jalr wins over jal, jal over br_taken; multi flags a multi-hot EX decode.
  function automatic redir_t decode_redir(input logic br_taken, input logic jal,
                                          input logic jalr);
    redir_t r;
    r.any   = br_taken | jal | jalr;
    r.multi = (br_taken & jal) | (br_taken & jalr) | (jal & jalr);
    r.sel   = jalr ? SEL_JALR : SEL_TGT;
    return r;
  endfunction

endpackage

// File: rtl/pc_sel_ctrl_sat_counter.sv
// Saturating up-counter used for the redirect performance count.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/pc_sel_ctrl.sv
// Next-PC sequencer: drives the 5-input PC mux select, squashes IF/ID on every
// redirect, holds bubbles while IMEM refills, and counts accepted redirects.
module pc_sel_ctrl
  import pc_sel_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h4000_0000,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_taken,
  input  logic             jal,
  input  logic             jalr,
  output logic [2:0]       pc_sel,
  output logic             flush_if,
  output logic             flush_id,
  output logic             boot_done,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic             multi_err
);

  // RESET_PC only feeds mux input 4 at the top level; catch a misaligned boot vector early.
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("pc_sel_ctrl: RESET_PC must be 4-byte aligned");
  end
  if (FLUSH_CYCLES < 0 || FLUSH_CYCLES > 7) begin : g_bad_flush
    $error("pc_sel_ctrl: FLUSH_CYCLES must be within 0..7");
  end

  localparam logic [SQ_W-1:0] SQ_INIT =
    (FLUSH_CYCLES == 0) ? '0 : SQ_W'(FLUSH_CYCLES - 1);

  fsm_e            fsm_q, fsm_d;
  logic [SQ_W-1:0] sq_cnt_q, sq_cnt_d;
  logic            boot_done_q, boot_done_d;
  logic            multi_err_q, multi_err_d;
  logic            flush;
  logic            cnt_inc;
  redir_t          rd;

  assign rd = decode_redir(br_taken, jal, jalr);

  always_comb begin
    fsm_d       = fsm_q;
    sq_cnt_d    = sq_cnt_q;
    boot_done_d = boot_done_q;
    multi_err_d = multi_err_q;
    pc_sel      = SEL_PC4;
    flush       = 1'b0;
    cnt_inc     = 1'b0;
    unique case (fsm_q)
      BOOT: begin
        pc_sel = SEL_RST;
        flush  = 1'b1;
        if (!stall) begin
          fsm_d       = RUN;
          boot_done_d = 1'b1;
        end
      end
      RUN: begin
        if (stall) begin
          pc_sel = SEL_HOLD;
        end else if (rd.any) begin
          pc_sel  = rd.sel;
          flush   = 1'b1;
          cnt_inc = 1'b1;
          if (rd.multi) multi_err_d = 1'b1;
          if (FLUSH_CYCLES != 0) begin
            fsm_d    = SQUASH;
            sq_cnt_d = SQ_INIT;
          end
        end
      end
      SQUASH: begin
        // EX only holds squashed bubbles here, so redirect inputs are ignored.
        flush = 1'b1;
        if (stall) begin
          pc_sel = SEL_HOLD;
        end else if (sq_cnt_q == '0) begin
          fsm_d = RUN;
        end else begin
          sq_cnt_d = sq_cnt_q - SQ_W'(1);
        end
      end
      default: begin
        pc_sel   = SEL_RST;
        flush    = 1'b1;
        fsm_d    = BOOT;
        sq_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= BOOT;
      sq_cnt_q    <= '0;
      boot_done_q <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      sq_cnt_q    <= sq_cnt_d;
      boot_done_q <= boot_done_d;
      multi_err_q <= multi_err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .count (redirect_cnt)
  );

  assign flush_if  = flush;
  assign flush_id  = flush;
  assign boot_done = boot_done_q;
  assign multi_err = multi_err_q;

endmodule
